probe_uplink_mux: RTL and testbench

Merges the uplink word streams of up to `NumProbes` probe blocks onto a single registered valid/ready uplink toward the serial probe transactor. Each probe is a trigger or capture block with the per-probe `DATAUP`/`DATAVALID`/`ACK` word handshake. The block grants one probe at a time, in round-robin order, and holds the grant for a whole multi-word message until that probe drops `DATAVALID`. It also ORs the probes' `DELAY` requests into one stall request for the controlled clock.

---
 rtl/probe_pkg.sv | 26 ++
 rtl/probe_uplink_mux_if.sv | 24 ++
 rtl/probe_rr_arbiter.sv | 28 ++
 rtl/probe_uplink_mux.sv | 102 ++++++++++
 tb/tb_probe_uplink_mux.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/probe_pkg.sv
// Shared probe word definitions: opcodes, padding pattern and 32-bit word layout.
package probe_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0]  PDISABLED  = 3'd1;
  localparam logic [2:0]  PENABLED   = 3'd2;
  localparam logic [2:0]  PTRIGGERED = 3'd3;
  localparam logic [12:0] PADDING    = 13'h1FFF;

  // Uplink word: probe id in the top half, constant padding, opcode in the low bits.
  typedef struct packed {
    logic [15:0] id;
    logic [12:0] padding;
    logic [2:0]  opcode;
  } probe_word_t;

  function automatic logic [WORD_W-1:0] mk_word(input logic [15:0] id, input logic [2:0] op);
    probe_word_t w;
    w.id      = id;
    w.padding = PADDING;
    w.opcode  = op;
    return w;
  endfunction

endpackage

// File: rtl/probe_uplink_mux_if.sv
// Bundle of the probe-side lanes and the registered uplink toward the transactor.
interface probe_uplink_mux_if #(
  parameter int NumProbes = 4
);
  logic [NumProbes-1:0]         dv;
  logic [NumProbes-1:0][31:0]   dataup;
  logic [NumProbes-1:0]         delay_in;
  logic [NumProbes-1:0]         ack;
  logic [31:0]                  out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         delay;
  logic                         busy;

  modport mux (
    input  dv, dataup, delay_in, out_ready,
    output ack, out_data, out_valid, delay, busy
  );

  modport probe (
    output dv, dataup, delay_in, out_ready,
    input  ack, out_data, out_valid, delay, busy
  );
endinterface

// File: rtl/probe_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
module probe_rr_arbiter #(
  parameter int NumProbes = 4,
  parameter int IdxWidth  = 2
) (
  input  logic [NumProbes-1:0] req,
  input  logic [IdxWidth-1:0]  last,
  output logic [IdxWidth-1:0]  gnt,
  output logic                 any
);

  int                  idx;
  logic [IdxWidth-1:0] idx_l;

  // Scan farthest-first so the nearest requester after 'last' wins the final write.
  always_comb begin
    gnt   = '0;
    idx   = 0;
    idx_l = '0;
    any   = |req;
    for (int k = NumProbes; k >= 1; k--) begin
      idx   = (int'(last) + k) % NumProbes;
      idx_l = IdxWidth'(idx);
      if (req[idx_l]) gnt = idx_l;
    end
  end

endmodule

// File: rtl/probe_uplink_mux.sv
// Round-robin merge of probe uplink word streams onto one registered valid/ready
// uplink. A grant is held for a whole message until the probe drops DATAVALID.
module probe_uplink_mux
  import probe_pkg::*;
#(
  parameter int NumProbes = 4,
  parameter int IdxWidth  = 2
) (
  input  logic                        UCLK,
  input  logic                        URST,
  input  logic [NumProbes-1:0]        DATAVALID_IN,
  input  logic [WORD_W*NumProbes-1:0] DATAUP_IN,
  input  logic [NumProbes-1:0]        DELAY_IN,
  output logic [NumProbes-1:0]        ACK_OUT,
  output logic [WORD_W-1:0]           OUT_DATA,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic                        DELAY,
  output logic                        BUSY
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IdxWidth-1:0] gnt_q, gnt_d;
  logic [IdxWidth-1:0] last_q, last_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;

  logic [NumProbes-1:0][WORD_W-1:0] lanes;
  logic [IdxWidth-1:0]              arb_gnt;
  logic                             arb_any;
  logic                             load;

  assign lanes = DATAUP_IN;

  probe_rr_arbiter #(
    .NumProbes (NumProbes),
    .IdxWidth  (IdxWidth)
  ) u_arb (
    .req  (DATAVALID_IN),
    .last (last_q),
    .gnt  (arb_gnt),
    .any  (arb_any)
  );

  // Grant FSM, ACK generation and output-register next state.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    ACK_OUT     = '0;
    load        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          last_d  = arb_gnt;
          state_d = S_GRANT;
        end
      end
      default: begin
        if (DATAVALID_IN[gnt_q]) begin
          // Take a word only if the output slot is free or draining this cycle.
          if (!out_valid_q || OUT_READY) begin
            ACK_OUT[gnt_q] = 1'b1;
            load           = 1'b1;
          end
        end else begin
          // Probe dropped valid: message complete, release the grant.
          state_d = S_IDLE;
        end
      end
    endcase
    out_data_d  = load ? lanes[gnt_q] : out_data_q;
    out_valid_d = load ? 1'b1 : (OUT_READY ? 1'b0 : out_valid_q);
  end

  // State and output registers; reset arms probe 0 as the first winner.
  always_ff @(posedge UCLK or negedge URST) begin
    if (!URST) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      last_q      <= IdxWidth'(NumProbes - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign DELAY     = |DELAY_IN;
  assign BUSY      = (state_q == S_GRANT) || out_valid_q;

endmodule

// File: tb/tb_probe_uplink_mux.sv
// Scoreboard bench: probe models stream queued words, expected uplink order is
// pushed by hand, a negedge monitor pops and compares every accepted word.
module tb_probe_uplink_mux;
  import probe_pkg::*;

  localparam int NP = 4;

  logic UCLK = 1'b0;
  logic URST = 1'b1;

  probe_uplink_mux_if #(.NumProbes(NP)) pif();

  probe_uplink_mux #(.NumProbes(NP), .IdxWidth(2)) dut (
    .UCLK         (UCLK),
    .URST         (URST),
    .DATAVALID_IN (pif.dv),
    .DATAUP_IN    (pif.dataup),
    .DELAY_IN     (pif.delay_in),
    .ACK_OUT      (pif.ack),
    .OUT_DATA     (pif.out_data),
    .OUT_VALID    (pif.out_valid),
    .OUT_READY    (pif.out_ready),
    .DELAY        (pif.delay),
    .BUSY         (pif.busy)
  );

  always #5 UCLK = ~UCLK;

  int n_chk  = 0;
  int n_fail = 0;
  int acks   = 0;
  int accepted = 0;

  // bit 32 set = one-cycle valid-low gap that ends a message
  logic [32:0] pq[NP][$];
  logic [31:0] expq[$];
  logic [NP-1:0] ack_seen = '0;
  bit gap_shown[NP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input int p, input logic [31:0] w);
    pq[p].push_back({1'b0, w});
  endtask

  task automatic end_msg(input int p);
    pq[p].push_back({1'b1, 32'h0});
  endtask

  function automatic bit probes_pending();
    for (int i = 0; i < NP; i++) if (pq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: sample ACKs for the probe models and score accepted words.
  always @(negedge UCLK) begin
    ack_seen = pif.ack;
    if (URST) begin
      if (pif.ack != '0) acks++;
      chk("ack_onehot", {31'd0, $onehot0(pif.ack)}, 32'd1);
      if (pif.out_valid && pif.out_ready) begin
        accepted++;
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_word: got %h expected none at %0t", pif.out_data, $time);
        end else begin
          chk("uplink_word", pif.out_data, expq.pop_front());
        end
      end
    end
  end

  // Probe models: present head word, advance on the edge after an ACK.
  initial begin
    pif.dv       = '0;
    pif.dataup   = '0;
    forever begin
      @(posedge UCLK);
      #2;
      for (int i = 0; i < NP; i++) begin
        if (pq[i].size() > 0) begin
          if (!pq[i][0][32] && ack_seen[i]) void'(pq[i].pop_front());
          else if (pq[i][0][32] && gap_shown[i]) void'(pq[i].pop_front());
        end
        gap_shown[i] = 1'b0;
        if (pq[i].size() == 0) begin
          pif.dv[i] = 1'b0;
        end else if (pq[i][0][32]) begin
          pif.dv[i]    = 1'b0;
          gap_shown[i] = 1'b1;
        end else begin
          pif.dv[i]     = 1'b1;
          pif.dataup[i] = pq[i][0][31:0];
        end
      end
    end
  end

  task automatic flush_models();
    for (int i = 0; i < NP; i++) begin
      pq[i].delete();
      gap_shown[i] = 1'b0;
    end
    expq.delete();
    pif.dv   = '0;
    acks     = 0;
    accepted = 0;
  endtask

  task automatic do_reset();
    @(posedge UCLK);
    #1 URST = 1'b0;
    flush_models();
    repeat (2) @(posedge UCLK);
    #1 URST = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((expq.size() != 0 || pif.busy || probes_pending()) && cyc < 300) begin
      @(negedge UCLK);
      cyc++;
    end
    chk({name, "_drain_in_time"}, {31'd0, cyc < 300}, 32'd1);
    chk({name, "_acks_eq_words"}, acks, accepted);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic [31:0] w_a, w_b;
    pif.out_ready = 1'b1;
    pif.delay_in  = '0;

    // ---- reset state
    #1 URST = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, pif.out_valid}, 32'd0);
    chk("rst_out_data", pif.out_data, 32'd0);
    chk("rst_ack", {28'd0, pif.ack}, 32'd0);
    chk("rst_busy", {31'd0, pif.busy}, 32'd0);
    repeat (2) @(posedge UCLK);
    #1 URST = 1'b1;

    // ---- single trigger message on probe 2, exact timing
    @(posedge UCLK);
    #1;
    w_a = mk_word(16'd5, PTRIGGERED);
    w_b = mk_word(16'd7, PTRIGGERED);
    chk("pkg_word_a", w_a, 32'h0005FFFB);
    push_word(2, w_a);
    push_word(2, w_b);
    end_msg(2);
    expq.push_back(32'h0005FFFB);
    expq.push_back(32'h0007FFFB);
    @(negedge UCLK);
    chk("t1_idle_ack", {28'd0, pif.ack}, 32'd0);
    @(negedge UCLK);
    chk("t1_ack1", {28'd0, pif.ack}, 32'h4);
    chk("t1_valid_pre", {31'd0, pif.out_valid}, 32'd0);
    @(negedge UCLK);
    chk("t1_ack2", {28'd0, pif.ack}, 32'h4);
    chk("t1_data1", pif.out_data, 32'h0005FFFB);
    @(negedge UCLK);
    chk("t1_ack3", {28'd0, pif.ack}, 32'd0);
    chk("t1_data2", pif.out_data, 32'h0007FFFB);
    chk("t1_busy_eom", {31'd0, pif.busy}, 32'd1);
    @(negedge UCLK);
    chk("t1_idle_after", {31'd0, pif.busy}, 32'd0);
    wait_drain("t1");

    // ---- simultaneous requests after reset: order 0,1,3 then 0 again
    do_reset();
    @(posedge UCLK);
    #1;
    push_word(0, 32'hA000_0010); push_word(0, 32'hA000_0011); end_msg(0);
    push_word(0, 32'hA000_0012); end_msg(0);
    push_word(1, 32'hA000_0020); end_msg(1);
    push_word(3, 32'hA000_0030); push_word(3, 32'hA000_0031);
    push_word(3, 32'hA000_0032); end_msg(3);
    expq.push_back(32'hA000_0010); expq.push_back(32'hA000_0011);
    expq.push_back(32'hA000_0020);
    expq.push_back(32'hA000_0030); expq.push_back(32'hA000_0031);
    expq.push_back(32'hA000_0032);
    expq.push_back(32'hA000_0012);
    wait_drain("t2");

    // ---- backpressure mid-message on probe 2
    @(posedge UCLK);
    #1;
    for (int k = 0; k < 4; k++) push_word(2, 32'hB000_0040 + k);
    end_msg(2);
    for (int k = 0; k < 4; k++) expq.push_back(32'hB000_0040 + k);
    cyc = 0;
    do begin
      @(negedge UCLK);
      cyc++;
    end while (!(pif.out_valid && pif.out_data == 32'hB000_0041) && cyc < 50);
    chk("t3_reach_word1", {31'd0, cyc < 50}, 32'd1);
    @(posedge UCLK);
    #1 pif.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge UCLK);
      chk("t3_stall_valid", {31'd0, pif.out_valid}, 32'd1);
      chk("t3_stall_data", pif.out_data, 32'hB000_0042);
      chk("t3_stall_ack", {28'd0, pif.ack}, 32'd0);
    end
    @(posedge UCLK);
    #1 pif.out_ready = 1'b1;
    wait_drain("t3");

    // ---- disable trailer on probe 1, probe 2 waits for release
    @(posedge UCLK);
    #1;
    push_word(1, mk_word(16'd5, PTRIGGERED));
    push_word(1, mk_word(16'd5, PDISABLED));
    end_msg(1);
    push_word(2, 32'hC000_0050); end_msg(2);
    expq.push_back(32'h0005FFFB);
    expq.push_back(32'h0005FFF9);
    expq.push_back(32'hC000_0050);
    cyc = 0;
    do begin
      @(negedge UCLK);
      cyc++;
    end while (!(pif.out_valid && pif.out_data == 32'h0005FFF9) && cyc < 50);
    chk("t4_reach_trailer", {31'd0, cyc < 50}, 32'd1);
    chk("t4_release_ack", {28'd0, pif.ack}, 32'd0);
    chk("t4_release_busy", {31'd0, pif.busy}, 32'd1);
    @(negedge UCLK);
    chk("t4_arb_ack", {28'd0, pif.ack}, 32'd0);
    @(negedge UCLK);
    chk("t4_next_ack", {28'd0, pif.ack}, 32'h4);
    wait_drain("t4");

    // ---- asynchronous reset during the second word
    @(posedge UCLK);
    #1;
    push_word(0, 32'hD000_0001); push_word(0, 32'hD000_0002);
    push_word(0, 32'hD000_0003); end_msg(0);
    repeat (2) @(posedge UCLK);
    #3 URST = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, pif.out_valid}, 32'd0);
    chk("t5_rst_ack", {28'd0, pif.ack}, 32'd0);
    chk("t5_rst_busy", {31'd0, pif.busy}, 32'd0);
    flush_models();
    repeat (2) @(posedge UCLK);
    #1 URST = 1'b1;
    @(posedge UCLK);
    #1;
    push_word(3, 32'hE000_0003); end_msg(3);
    push_word(0, 32'hE000_0000); end_msg(0);
    expq.push_back(32'hE000_0000);
    expq.push_back(32'hE000_0003);
    @(negedge UCLK);
    @(negedge UCLK);
    chk("t5_first_gnt", {28'd0, pif.ack}, 32'h1);
    wait_drain("t5");

    // ---- DELAY is a zero-latency OR
    @(posedge UCLK);
    #1 pif.delay_in = 4'b1000;
    #1 chk("t6_delay_set", {31'd0, pif.delay}, 32'd1);
    pif.delay_in = 4'b0000;
    #1 chk("t6_delay_clr", {31'd0, pif.delay}, 32'd0);
    push_word(1, 32'hF000_0001); end_msg(1);
    expq.push_back(32'hF000_0001);
    @(negedge UCLK);
    @(negedge UCLK);
    pif.delay_in = 4'b0100;
    #1 chk("t6_delay_busy", {31'd0, pif.delay}, 32'd1);
    pif.delay_in = 4'b0000;
    #1 chk("t6_delay_busy_clr", {31'd0, pif.delay}, 32'd0);
    wait_drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
